display: RTL and testbench
==========================

Name: display

Overview:
- Registered 5-bit to 7-segment decoder; drives one digit of the board display.
- Codes 0-15 show hexadecimal glyphs 0-F; codes 16-31 show a fixed set of letters and symbols.
- One segment per output (a..g).
- Sits between datapath result registers and the physical digit pins.

Parameters:
- ACTIVE_LOW, default 0: 0 = a lit segment is driven 1; 1 = all seven outputs inverted (common-anode board).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears the outputs immediately on assertion.
- en  input  1  load enable; entrada is sampled only when en=1.
- entrada  input  5  code to display, unsigned 0-31.
- a  output  1  segment a (top).
- b  output  1  segment b (upper right).
- c  output  1  segment c (lower right).
- d  output  1  segment d (bottom).
- e  output  1  segment e (lower left).
- f  output  1  segment f (upper left).
- g  output  1  segment g (middle).

Behaviour:
- Reset:
  - rst=1 forces a..g to the "all off" state asynchronously: 0000000 if ACTIVE_LOW=0, 1111111 if ACTIVE_LOW=1.
  - Outputs hold that state while rst=1. The first load happens on the first rising clk edge with rst=0 and en=1.
- Decode and latency:
  - On a rising clk edge with en=1, the decoded pattern of entrada is registered into a..g. This is 1-cycle latency.
  - With en=0, outputs hold their previous value.
  - No combinational path from entrada to the outputs.
- Pattern table, written as abcdefg with 1 = lit. With ACTIVE_LOW=1, the driven value is the bitwise inverse.
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011
  - 10 A=1110111, 11 b=0011111, 12 C=1001110, 13 d=0111101
  - 14 E=1001111, 15 F=1000111
  - 16 G=1011110, 17 H=0110111, 18 J=0111100, 19 L=0001110
  - 20 n=0010101, 21 o=0011101, 22 P=1100111, 23 q=1110011
  - 24 r=0000101, 25 t=0001111, 26 U=0111110, 27 y=0111011
  - 28 dash=0000001, 29 underscore=0001000, 30 overbar=1000000, 31 blank=0000000
- Table completeness:
  - All 32 codes are defined; no don't-cares.
  - Any X/Z bit on entrada while en=1 is not required to produce a defined pattern.
- Timing corner cases:
  - rst asserted mid-operation clears the outputs without waiting for clk.
  - rst deasserting on the same edge as en=1 does not load on that edge; the load happens on the next edge.
  - entrada changing while en=0 has no effect.
  - Back-to-back loads on consecutive edges each update the outputs on their own edge.
- Output port order is a,b,c,d,e,f,g, following entrada; positional instantiation must keep this order.

Test Plan:
- Reset: rst=1 with random entrada and en=1 -> a..g=0000000 immediately; stays 0000000 until after release.
- Full sweep: rst=0, en=1, entrada stepped 00000 through 11111, one code per clock -> each pattern matches the table one edge later (e.g. 00000->1111110, 01010->1110111, 10000->1011110, 11111->0000000).
- Hold: load 00011 (->1111001), then en=0 and drive entrada=01000 for 5 clocks -> outputs stay 1111001; en=1 -> 1111111 on the next edge.
- Async reset mid-stream: outputs showing 1111111, assert rst between edges -> 0000000 before the next clk edge; release with en=1 and entrada=00001 -> 0110000 one edge after release.
- Polarity: ACTIVE_LOW=1 -> reset gives 1111111; entrada=00000 -> 0000001; entrada=11100 -> 1111110.

Source files
------------

// File: rtl/display.sv
// Registered 5-bit code to 7-segment decoder for one board digit.
// Codes 0-15 show hex glyphs, 16-31 show letters/symbols.
// ACTIVE_LOW=1 inverts every segment for common-anode boards.
module display #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] entrada,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g
);

    // Pattern with every segment dark, in the driven polarity.
    localparam logic [6:0] OFF_PATTERN = ACTIVE_LOW ? 7'b111_1111 : 7'b000_0000;

    // Registered segment vector, ordered abcdefg (bit 6 = a).
    logic [6:0] seg_q;
    logic [6:0] seg_d;
    logic [6:0] glyph;

    // Code to lit-segment pattern (1 = lit), before polarity is applied.
    always_comb begin
        glyph = '0;
        case (entrada)
            5'd0:  glyph = 7'b1111110;
            5'd1:  glyph = 7'b0110000;
            5'd2:  glyph = 7'b1101101;
            5'd3:  glyph = 7'b1111001;
            5'd4:  glyph = 7'b0110011;
            5'd5:  glyph = 7'b1011011;
            5'd6:  glyph = 7'b1011111;
            5'd7:  glyph = 7'b1110000;
            5'd8:  glyph = 7'b1111111;
            5'd9:  glyph = 7'b1111011;
            5'd10: glyph = 7'b1110111; // A
            5'd11: glyph = 7'b0011111; // b
            5'd12: glyph = 7'b1001110; // C
            5'd13: glyph = 7'b0111101; // d
            5'd14: glyph = 7'b1001111; // E
            5'd15: glyph = 7'b1000111; // F
            5'd16: glyph = 7'b1011110; // G
            5'd17: glyph = 7'b0110111; // H
            5'd18: glyph = 7'b0111100; // J
            5'd19: glyph = 7'b0001110; // L
            5'd20: glyph = 7'b0010101; // n
            5'd21: glyph = 7'b0011101; // o
            5'd22: glyph = 7'b1100111; // P
            5'd23: glyph = 7'b1110011; // q
            5'd24: glyph = 7'b0000101; // r
            5'd25: glyph = 7'b0001111; // t
            5'd26: glyph = 7'b0111110; // U
            5'd27: glyph = 7'b0111011; // y
            5'd28: glyph = 7'b0000001; // dash
            5'd29: glyph = 7'b0001000; // underscore
            5'd30: glyph = 7'b1000000; // overbar
            5'd31: glyph = 7'b0000000; // blank
            default: glyph = '0;
        endcase
    end

    // Next-state: load the polarity-adjusted glyph when enabled, else hold.
    always_comb begin
        seg_d = seg_q;
        if (en) begin
            seg_d = ACTIVE_LOW ? ~glyph : glyph;
        end
    end

    // Segment register; reset blanks the digit without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= OFF_PATTERN;
        end else begin
            seg_q <= seg_d;
        end
    end

    // Segments driven straight from the register, no path from entrada.
    always_comb begin
        a = seg_q[6];
        b = seg_q[5];
        c = seg_q[4];
        d = seg_q[3];
        e = seg_q[2];
        f = seg_q[1];
        g = seg_q[0];
    end

endmodule

// File: tb/tb_display.sv
// Self-checking bench for display: both polarities against a glyph-table model.
module tb_display;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] entrada;
    logic       a0, b0, c0, d0, e0, f0, g0;
    logic       a1, b1, c1, d1, e1, f1, g1;

    int unsigned n_checks;
    int unsigned n_fail;

    // Reference: lit-segment glyph per code, abcdefg with 1 = lit.
    logic [6:0] glyph_tbl [32];
    // Model of what is currently shown, as lit segments (polarity-free).
    logic [6:0] shown;

    display #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .entrada(entrada),
        .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0)
    );

    display #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .entrada(entrada),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model: high-active shows the glyph,
    // low-active shows its inverse.
    task automatic check_both(input string tag);
        check_eq({tag, "/hi"}, {a0, b0, c0, d0, e0, f0, g0}, shown);
        check_eq({tag, "/lo"}, {a1, b1, c1, d1, e1, f1, g1}, ~shown);
    endtask

    // One rising edge: update the model from the inputs seen at that edge, then check.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst && en) shown = glyph_tbl[entrada];
        #1;
        check_both(tag);
    endtask

    initial begin
        glyph_tbl = '{
            7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
            7'b1011110, 7'b0110111, 7'b0111100, 7'b0001110,
            7'b0010101, 7'b0011101, 7'b1100111, 7'b1110011,
            7'b0000101, 7'b0001111, 7'b0111110, 7'b0111011,
            7'b0000001, 7'b0001000, 7'b1000000, 7'b0000000
        };
        n_checks = 0;
        n_fail   = 0;

        // Reset with enable and random codes: digit stays dark.
        rst     = 1'b1;
        en      = 1'b1;
        entrada = 5'($urandom);
        shown   = '0;
        #3;
        check_both("reset_async");
        for (int i = 0; i < 3; i++) begin
            entrada = 5'($urandom);
            tick("reset_hold");
            #0;
        end

        // Release just after an edge; first load on the next edge.
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            entrada = 5'(i);
            en      = 1'b1;
            tick("sweep");
        end

        // Hold: load 3 then change entrada with en low.
        entrada = 5'd3;
        tick("hold_load");
        check_eq("hold_load_val", {a0, b0, c0, d0, e0, f0, g0}, 7'b1111001);
        en      = 1'b0;
        entrada = 5'd8;
        for (int i = 0; i < 5; i++) tick("hold");
        check_eq("hold_val", {a0, b0, c0, d0, e0, f0, g0}, 7'b1111001);
        en = 1'b1;
        tick("hold_release");
        check_eq("hold_release_val", {a0, b0, c0, d0, e0, f0, g0}, 7'b1111111);

        // Async reset between edges, then release with code 1.
        #2;
        rst   = 1'b1;
        shown = '0;
        #1;
        check_both("midreset");
        @(posedge clk);
        #1;
        check_both("midreset_edge");
        rst     = 1'b0;
        en      = 1'b1;
        entrada = 5'd1;
        tick("midreset_release");
        check_eq("midreset_release_val", {a0, b0, c0, d0, e0, f0, g0}, 7'b0110000);

        // Polarity spot checks on the low-active instance.
        entrada = 5'd0;
        tick("pol0");
        check_eq("pol0_lo", {a1, b1, c1, d1, e1, f1, g1}, 7'b0000001);
        entrada = 5'd28;
        tick("pol28");
        check_eq("pol28_lo", {a1, b1, c1, d1, e1, f1, g1}, 7'b1111110);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 300; i++) begin
            en      = 1'($urandom);
            entrada = 5'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                #2;
                rst   = 1'b1;
                shown = '0;
                #1;
                check_both("rand_rst");
                tick("rand_rst_edge");
                rst = 1'b0;
            end else begin
                tick("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
